// File: rtl/fifo_3way_pkg.sv
// Shared types and helpers for the 3-way FIFO write/read side logic.
package fifo_3way_pkg;

  localparam int BYTE_W = 8;
  localparam int LANES  = 3;

  typedef logic [LANES-1:0] lane_vec_t;

  typedef enum logic [1:0] {EMPTY, HOLD, ISSUE} pack_state_t;

  // Thermometer code of a lane count 0..3 (lane 0 fills first).
  function automatic lane_vec_t thermo(input logic [1:0] n);
    case (n)
      2'd0:    return 3'b000;
      2'd1:    return 3'b001;
      2'd2:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/lane_accept_count.sv
// Leading-ones count of (valid & able): how many lanes, from lane 0 upward,
// were actually taken. A gap stops the count.
module lane_accept_count
  import fifo_3way_pkg::*;
(
  input  logic [LANES-1:0] valid_i,
  input  logic [LANES-1:0] able_i,
  output logic [1:0]       accepted_o
);

  logic [LANES-1:0] taken;

  assign taken = valid_i & able_i;

  always_comb begin
    accepted_o = 2'd0;
    if (taken[0]) begin
      accepted_o = 2'd1;
      if (taken[1]) begin
        accepted_o = 2'd2;
        if (taken[2]) accepted_o = 2'd3;
      end
    end
  end

endmodule

// File: rtl/fifo_3way_packer.sv
// Serial-to-3-lane packer: stages bytes in a circular store and offers up to
// three oldest bytes per cycle, holding partial groups for a bounded time.
module fifo_3way_packer
  import fifo_3way_pkg::*;
#(
  parameter int DEPTH       = 6,
  parameter int HOLD_CYCLES = 4
)
(
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [BYTE_W-1:0]          in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       flush,
  output logic [BYTE_W-1:0]          data_in_0,
  output logic [BYTE_W-1:0]          data_in_1,
  output logic [BYTE_W-1:0]          data_in_2,
  output logic [LANES-1:0]           valid_in,
  input  logic [LANES-1:0]           able_in,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int AW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [AW-1:0] HOLD_V = AW'(HOLD_CYCLES);

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic [AW-1:0]     age_q, age_d;
  logic              flushPend_q, flushPend_d;
  pack_state_t       state_q, state_d;

  logic              push;
  logic [1:0]        accepted;
  logic [1:0]        groupSize;
  lane_vec_t         laneValid;
  logic [BYTE_W-1:0] laneData [LANES];

  // Pointer advance with explicit wrap so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] wrapAdd(input logic [PW-1:0] ptr, input logic [1:0] inc);
    logic [PW:0] sum;
    sum = {1'b0, ptr} + {{(PW-1){1'b0}}, inc};
    if (sum >= (PW+1)'(DEPTH)) sum = sum - (PW+1)'(DEPTH);
    return sum[PW-1:0];
  endfunction

  assign in_ready  = (count_q < CW'(DEPTH));
  assign push      = in_valid & in_ready;
  assign groupSize = (count_q >= CW'(3)) ? 2'd3 : count_q[1:0];
  assign laneValid = (state_q == ISSUE) ? thermo(groupSize) : '0;
  assign valid_in  = laneValid;
  assign count     = count_q;

  lane_accept_count uAccept (
    .valid_i    (laneValid),
    .able_i     (able_in),
    .accepted_o (accepted)
  );

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      laneData[i] = laneValid[i] ? mem_q[wrapAdd(head_q, 2'(i))] : '0;
    end
  end

  assign data_in_0 = laneData[0];
  assign data_in_1 = laneData[1];
  assign data_in_2 = laneData[2];

  // Next state is computed from the next-cycle count/age/flush so the
  // registered state always matches the registered counters.
  always_comb begin
    head_d      = wrapAdd(head_q, accepted);
    tail_d      = push ? wrapAdd(tail_q, 2'd1) : tail_q;
    count_d     = count_q + CW'(push) - CW'(accepted);
    flushPend_d = flushPend_q | (flush & (count_q != '0));
    if (count_d == '0) flushPend_d = 1'b0;

    age_d = age_q;
    if (count_d == '0 || accepted != 2'd0) age_d = '0;
    else if (count_q != '0 && age_q < HOLD_V) age_d = age_q + AW'(1);

    state_d = HOLD;
    if (count_d == '0) state_d = EMPTY;
    else if (count_d >= CW'(3) || age_d >= HOLD_V || flushPend_d) state_d = ISSUE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      age_q       <= '0;
      flushPend_q <= 1'b0;
      state_q     <= EMPTY;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      age_q       <= age_d;
      flushPend_q <= flushPend_d;
      state_q     <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= in_data;
  end

endmodule

// File: tb/tb_fifo_3way_packer.sv
// Self-checking bench for fifo_3way_packer: table-driven cycle vectors plus a
// byte-order scoreboard fed on every push and drained on every accepted lane.
module tb_fifo_3way_packer;

  logic       clk;
  logic       reset_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       flush;
  logic [7:0] data_in_0, data_in_1, data_in_2;
  logic [2:0] valid_in;
  logic [2:0] able_in;
  logic [2:0] count;

  int checks   = 0;
  int failures = 0;
  logic [7:0] sbQ [$];

  typedef struct {
    logic       inValid;
    logic [7:0] inData;
    logic [2:0] able;
    logic       fl;
    logic [2:0] expValid;
    logic [2:0] expCount;
    logic       expReady;
    logic [7:0] expD0;
    logic [7:0] expD1;
    logic [7:0] expD2;
  } vec_t;

  vec_t vecs [$];

  fifo_3way_packer #(.DEPTH(6), .HOLD_CYCLES(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .data_in_0 (data_in_0),
    .data_in_1 (data_in_1),
    .data_in_2 (data_in_2),
    .valid_in  (valid_in),
    .able_in   (able_in),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic [2:0] ab, input logic f);
    in_valid = v;
    in_data  = d;
    able_in  = ab;
    flush    = f;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mkVec(input logic v, input logic [7:0] d, input logic [2:0] ab,
                                 input logic f, input logic [2:0] ev, input logic [2:0] ec,
                                 input logic er, input logic [7:0] d0, input logic [7:0] d1,
                                 input logic [7:0] d2);
    vec_t r;
    r = '{v, d, ab, f, ev, ec, er, d0, d1, d2};
    return r;
  endfunction

  // Scoreboard: lanes taken this cycle must match the oldest pushed bytes.
  always @(negedge clk) begin
    logic [2:0] taken;
    logic [7:0] laneVal;
    int         nTaken;
    if (!reset_n) begin
      sbQ.delete();
    end else begin
      taken  = able_in & valid_in;
      nTaken = 0;
      for (int k = 0; k < 3; k++) if (taken[k] && nTaken == k) nTaken++;
      for (int k = 0; k < nTaken; k++) begin
        laneVal = (k == 0) ? data_in_0 : (k == 1) ? data_in_1 : data_in_2;
        if (sbQ.size() == 0) begin
          checkOutput($sformatf("sb_underflow_lane%0d", k), 32'(laneVal), 32'hFFFF_FFFF);
        end else begin
          checkOutput($sformatf("sb_lane%0d", k), 32'(laneVal), 32'(sbQ.pop_front()));
        end
      end
      if (in_valid && in_ready) sbQ.push_back(in_data);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    able_in  = 3'b000;
    flush    = 1'b0;

    // inputs: valid, data, able, flush | expected: valid_in, count, in_ready, lanes 0..2
    vecs.push_back(mkVec(1, 8'h11, 3'b111, 0, 3'b000, 3'd1, 1, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mkVec(1, 8'h22, 3'b111, 0, 3'b000, 3'd2, 1, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mkVec(1, 8'h33, 3'b111, 0, 3'b111, 3'd3, 1, 8'h11, 8'h22, 8'h33));
    vecs.push_back(mkVec(0, 8'h00, 3'b111, 0, 3'b000, 3'd0, 1, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mkVec(1, 8'hA5, 3'b000, 0, 3'b000, 3'd1, 1, 8'h00, 8'h00, 8'h00));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mkVec(0, 8'h00, 3'b000, 0, 3'b000, 3'd1, 1, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mkVec(0, 8'h00, 3'b000, 0, 3'b001, 3'd1, 1, 8'hA5, 8'h00, 8'h00));
    vecs.push_back(mkVec(0, 8'h00, 3'b001, 0, 3'b000, 3'd0, 1, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mkVec(1, 8'h01, 3'b000, 0, 3'b000, 3'd1, 1, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mkVec(1, 8'h02, 3'b000, 0, 3'b000, 3'd2, 1, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mkVec(0, 8'h00, 3'b000, 1, 3'b011, 3'd2, 1, 8'h01, 8'h02, 8'h00));
    vecs.push_back(mkVec(0, 8'h00, 3'b011, 0, 3'b000, 3'd0, 1, 8'h00, 8'h00, 8'h00));
    // A lone byte after the flush drained must wait the full hold again.
    vecs.push_back(mkVec(1, 8'h03, 3'b000, 0, 3'b000, 3'd1, 1, 8'h00, 8'h00, 8'h00));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mkVec(0, 8'h00, 3'b000, 0, 3'b000, 3'd1, 1, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mkVec(0, 8'h00, 3'b000, 0, 3'b001, 3'd1, 1, 8'h03, 8'h00, 8'h00));
    vecs.push_back(mkVec(0, 8'h00, 3'b001, 0, 3'b000, 3'd0, 1, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mkVec(1, 8'hB0, 3'b000, 0, 3'b000, 3'd1, 1, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mkVec(1, 8'hB1, 3'b000, 0, 3'b000, 3'd2, 1, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mkVec(1, 8'hB2, 3'b000, 0, 3'b111, 3'd3, 1, 8'hB0, 8'hB1, 8'hB2));
    vecs.push_back(mkVec(1, 8'hB3, 3'b000, 0, 3'b111, 3'd4, 1, 8'hB0, 8'hB1, 8'hB2));
    vecs.push_back(mkVec(1, 8'hB4, 3'b000, 0, 3'b111, 3'd5, 1, 8'hB0, 8'hB1, 8'hB2));
    vecs.push_back(mkVec(1, 8'hB5, 3'b000, 0, 3'b111, 3'd6, 0, 8'hB0, 8'hB1, 8'hB2));
    vecs.push_back(mkVec(1, 8'hB6, 3'b000, 0, 3'b111, 3'd6, 0, 8'hB0, 8'hB1, 8'hB2));
    // Full with push and pop together: push blocked, pop of two proceeds.
    vecs.push_back(mkVec(1, 8'hB6, 3'b011, 0, 3'b111, 3'd4, 1, 8'hB2, 8'hB3, 8'hB4));
    vecs.push_back(mkVec(1, 8'hB6, 3'b000, 0, 3'b111, 3'd5, 1, 8'hB2, 8'hB3, 8'hB4));
    vecs.push_back(mkVec(0, 8'h00, 3'b101, 0, 3'b111, 3'd4, 1, 8'hB3, 8'hB4, 8'hB5));
    vecs.push_back(mkVec(0, 8'h00, 3'b111, 0, 3'b000, 3'd1, 1, 8'h00, 8'h00, 8'h00));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mkVec(0, 8'h00, 3'b111, 0, 3'b000, 3'd1, 1, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mkVec(0, 8'h00, 3'b111, 0, 3'b001, 3'd1, 1, 8'hB6, 8'h00, 8'h00));
    vecs.push_back(mkVec(0, 8'h00, 3'b111, 0, 3'b000, 3'd0, 1, 8'h00, 8'h00, 8'h00));

    #1;
    checkOutput("reset_valid_in", 32'(valid_in), 32'h0);
    checkOutput("reset_count", 32'(count), 32'h0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'h1);
    @(posedge clk);
    @(posedge clk);
    #3;
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].inValid, vecs[i].inData, vecs[i].able, vecs[i].fl);
      checkOutput($sformatf("v%0d_valid_in", i), 32'(valid_in), 32'(vecs[i].expValid));
      checkOutput($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].expCount));
      checkOutput($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].expReady));
      checkOutput($sformatf("v%0d_lane0", i), 32'(data_in_0), 32'(vecs[i].expD0));
      checkOutput($sformatf("v%0d_lane1", i), 32'(data_in_1), 32'(vecs[i].expD1));
      checkOutput($sformatf("v%0d_lane2", i), 32'(data_in_2), 32'(vecs[i].expD2));
    end
    checkOutput("table_sb_empty", 32'(sbQ.size()), 32'h0);

    // Asynchronous reset while a full group is on offer.
    applyStimulus(1, 8'hC0, 3'b000, 0);
    applyStimulus(1, 8'hC1, 3'b000, 0);
    applyStimulus(1, 8'hC2, 3'b000, 0);
    in_valid = 1'b0;
    checkOutput("pre_reset_valid_in", 32'(valid_in), 32'h7);
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset_valid_in", 32'(valid_in), 32'h0);
    checkOutput("async_reset_lane0", 32'(data_in_0), 32'h0);
    checkOutput("async_reset_lane2", 32'(data_in_2), 32'h0);
    checkOutput("async_reset_count", 32'(count), 32'h0);
    checkOutput("async_reset_in_ready", 32'(in_ready), 32'h1);
    @(posedge clk);
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    applyStimulus(0, 8'h00, 3'b000, 0);
    checkOutput("post_reset_count", 32'(count), 32'h0);
    checkOutput("post_reset_in_ready", 32'(in_ready), 32'h1);
    checkOutput("post_reset_valid_in", 32'(valid_in), 32'h0);

    applyStimulus(1, 8'hD0, 3'b111, 0);
    applyStimulus(1, 8'hD1, 3'b111, 0);
    applyStimulus(1, 8'hD2, 3'b111, 0);
    checkOutput("post_reset_group_valid", 32'(valid_in), 32'h7);
    checkOutput("post_reset_group_lane0", 32'(data_in_0), 32'hD0);
    checkOutput("post_reset_group_lane2", 32'(data_in_2), 32'hD2);
    applyStimulus(0, 8'h00, 3'b111, 0);
    checkOutput("post_reset_drain_count", 32'(count), 32'h0);
    applyStimulus(0, 8'h00, 3'b000, 0);
    checkOutput("final_sb_empty", 32'(sbQ.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_3way_packer.md
# fifo_3way_packer

Upstream feeder for the 3-way FIFO. It takes a serial byte stream under a valid/ready handshake and buffers it in a small circular staging store. It presents up to three oldest bytes per cycle on the FIFO's 3-lane write port and retires whatever the FIFO accepts. Partial groups of 1–2 bytes are held for a bounded time so that lane use is maximised, then issued.

## Interface
- `DEPTH`, default 6: staging entries. Legal range 3–15; need not be a power of two.
- `HOLD_CYCLES`, default 4: maximum cycles a partial group waits before issue. 0 means partial groups issue immediately.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `reset_n`  in  1: reset, asynchronous and active-low.
- `in_data`  in  8: serial input byte.
- `in_valid`  in  1: `in_data` is valid.
- `in_ready`  out  1: staging can accept a byte this cycle.
- `flush`  in  1: one-cycle pulse; issue all held bytes without waiting for the hold timer.
- `data_in_0` / `data_in_1` / `data_in_2`  out  8 each: lanes 0–2. Lane 0 holds the oldest byte.
- `valid_in`  out  3: thermometer lane-valid code, one of 000, 001, 011 or 111.
- `able_in`  in  3: FIFO per-lane accept for this cycle.
- `count`  out  $clog2(DEPTH+1): current occupancy.

## Operation
- **Push:** occurs when `in_valid & in_ready`. `in_ready = (count < DEPTH)` and depends on registered count only. A pop in the same cycle does not free space for a push in that cycle.
- **Presented group:** `n = min(count, 3)`. `valid_in` is the thermometer code of `n` when the issue condition is true, otherwise 000. Lanes at or above `n`, and all lanes when `valid_in = 000`, drive 8'h00.
- **Issue condition:** `(count >= 3) | (count > 0 & (age >= HOLD_CYCLES | flush_pend))`.
- **Accepted count `a`:** the number of consecutive 1s in `able_in & valid_in`, starting from bit 0. Bits after the first 0 are ignored, so 101 gives `a = 1`.
- **Pop and write:** `a` bytes retire from the head. The push writes at the tail. `count_next = count + push - a`.
- **Pointers:** head and tail wrap modulo `DEPTH` by explicit compare. They do not rely on binary overflow.
- **Age counter:**
  - Cleared when `count_next == 0` or `a > 0`.
  - Otherwise increments while `count > 0`.
  - Saturates at `HOLD_CYCLES`.
- **Flush:** `flush` sets `flush_pend`. `flush_pend` clears on the cycle `count_next == 0`. A flush while empty is a no-op.
- **State machine** (encoding of which lane group is presented):
  - EMPTY: `count == 0`.
  - HOLD: `0 < count < 3` and no issue.
  - ISSUE: issue condition true.
  - State is derived from registered count, age and `flush_pend`. `valid_in` is a function of registered state only.
- **Ordering:** output bytes leave in exact input order. No byte is dropped or duplicated.

## Timing
- No combinational path from `able_in` or `in_valid` to any output. `able_in` affects state only at the next edge, which breaks the loop through the FIFO's combinational `able_in`.
- **Latency, push to presentable:** 1 cycle; a byte pushed at edge k can appear at edge k+1.
- **Latency, full group:** issues the cycle its third byte is resident.
- **Latency, partial group:** issues no later than `HOLD_CYCLES` cycles after it becomes resident, or 1 cycle after `flush`.
- **`valid_in` stability:** may drop from 111 to 011 only after a pop. Lanes are never revoked without acceptance unless `count` falls.
- **Reset (asynchronous, any time, including mid-issue):**
  - head, tail, count, age and `flush_pend` go to 0.
  - `valid_in` goes to 000 and all data lanes to 8'h00.
  - `in_ready` goes to 1.
  - Staging contents are don't-care.
- **Boundary, full:** `in_ready = 0` and `in_valid` is ignored.
- **Boundary, empty:** `valid_in = 000`.
- **Boundary, simultaneous full, push and pop:** the push is blocked and the pop proceeds.

## Structure
- **Shared package `fifo_3way_pkg`:**
  - `BYTE_W = 8`.
  - `LANES = 3`.
  - Typedef `lane_vec_t` (logic [LANES-1:0]).
  - Enum `pack_state_t {EMPTY, HOLD, ISSUE}`.
  - The thermometer helper function.
- **Sub-module `lane_accept_count`:** combinational. Takes `valid_in` and `able_in` and produces the 2-bit accepted count `a` (leading-ones count). It is reused on the FIFO read side.

## Test plan
1. **Full groups:** reset, push 8'h11, 22, 33 on consecutive cycles with `able_in` = 111 → `valid_in` = 111 on lanes 11/22/33 for one cycle, then 000 and `count` = 0.
2. **Hold timer:** `HOLD_CYCLES = 4`, push a single 8'hA5 → `valid_in` stays 000 for 4 cycles, then 001 with `data_in_0` = A5. With `able_in` = 001, `count` is 0 the next cycle.
3. **Flush:** push 8'h01, 02, then pulse `flush` → `valid_in` = 011 the next cycle. `flush_pend` clears after acceptance.
4. **Backpressure and full:** `DEPTH = 6`, `able_in` = 000, push 7 bytes → `in_ready` drops after the 6th byte and the 7th is held off. Then `able_in` = 011 → 2 bytes retire, `valid_in` stays 111 and order is preserved across the pointer wrap.
5. **Partial accept and gapped `able_in`:** 5 bytes resident, `able_in` = 101 → `a = 1`, lane 0 retires, and the next lanes show bytes 2, 3, 4.
6. **Reset mid-issue:** `valid_in` = 111, `reset_n` asserted mid-cycle → outputs clear immediately with no clock. After release, `count` = 0 and `in_ready` = 1.
